// File: rtl/filter_mem_ctrl.sv
// rtl/filter_mem_ctrl.sv - filter sparse-memory load/read sequencer
//
// Purpose: turns a valid/ready stream of compressed filter beats into indexed
// memory writes, and walks a read window of chunks for the compute-unit feed.
// Reads of chunks not yet fully written are held off while a load is running.
//
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   ld_start_i, ld_chunk_num_i           start a load of chunks 0..num-1
//   in_valid_i/in_ready_o, in_*          input beat stream
//   wr_valid_o, wr_*                     registered memory write port
//   ld_busy_o, ld_done_o                 load status / completion pulse
//   rd_start_i, rd_chunk_base_i/num_i    start a read window
//   rd_stall_i                           consumer stall
//   rd_dat_count_o, rd_chunk_count_o     read address
//   rd_valid_o, rd_last_o                read beat qualifier / final beat
//   rd_done_o, rd_err_o                  read completion / rejected start
module filter_mem_ctrl #(
  parameter int BUS_SIZE  = 32,
  parameter int MEM_SIZE  = 128,
  parameter int CHUNK_NUM = 8,
  localparam int DAT_CYC  = MEM_SIZE / BUS_SIZE,
  localparam int CW       = $clog2(CHUNK_NUM),
  localparam int DW       = $clog2(DAT_CYC),
  localparam int NW       = $clog2(CHUNK_NUM + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ld_start_i,
  input  logic [NW-1:0]         ld_chunk_num_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [BUS_SIZE-1:0]   in_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0] in_nonzero_data_i,
  output logic                  wr_valid_o,
  output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
  output logic [DW-1:0]         wr_dat_count_o,
  output logic [CW-1:0]         wr_chunk_count_o,
  output logic                  ld_busy_o,
  output logic                  ld_done_o,
  input  logic                  rd_start_i,
  input  logic [CW-1:0]         rd_chunk_base_i,
  input  logic [NW-1:0]         rd_chunk_num_i,
  input  logic                  rd_stall_i,
  output logic [DW-1:0]         rd_dat_count_o,
  output logic [CW-1:0]         rd_chunk_count_o,
  output logic                  rd_valid_o,
  output logic                  rd_last_o,
  output logic                  rd_done_o,
  output logic                  rd_err_o
);

  localparam logic [DW-1:0] DAT_LAST  = DW'(DAT_CYC - 1);
  localparam logic [NW:0]   CHUNK_LIM = (NW+1)'(CHUNK_NUM);

  typedef enum logic {LD_IDLE, LD_LOAD} ld_state_t;
  typedef enum logic {RD_IDLE, RD_RUN}  rd_state_t;

  ld_state_t r_ld_state, w_ld_state_nxt;
  rd_state_t r_rd_state, w_rd_state_nxt;

  logic [DW-1:0]         r_ld_dat;
  logic [CW-1:0]         r_ld_chunk;
  logic [NW-1:0]         r_ld_num;
  logic [NW-1:0]         r_loaded_cnt;
  logic                  r_ld_done;
  logic                  r_wr_valid;
  logic [BUS_SIZE-1:0]   r_wr_sparsemap;
  logic [BUS_SIZE*8-1:0] r_wr_data;
  logic [DW-1:0]         r_wr_dat;
  logic [CW-1:0]         r_wr_chunk;

  logic [DW-1:0]         r_rd_dat;
  logic [CW-1:0]         r_rd_chunk;
  logic [CW-1:0]         r_rd_last_chunk;
  logic                  r_rd_done;
  logic                  r_rd_err;

  logic                  w_ld_start_ok;
  logic                  w_ld_enter;
  logic                  w_accept;
  logic                  w_ld_last_beat;
  logic                  w_chunk_done;
  logic [NW:0]           w_rd_end_sum;
  logic                  w_rd_start_ok;
  logic                  w_rd_valid;
  logic                  w_rd_final;
  logic                  w_rd_consume;

  // ---------------- load side ----------------
  assign w_ld_start_ok  = ld_start_i && (ld_chunk_num_i != '0) &&
                          ((NW+1)'(ld_chunk_num_i) <= CHUNK_LIM);
  assign w_ld_enter     = (r_ld_state == LD_IDLE) && w_ld_start_ok;
  assign in_ready_o     = (r_ld_state == LD_LOAD);
  assign ld_busy_o      = in_ready_o;
  assign w_accept       = in_valid_i && in_ready_o;
  assign w_ld_last_beat = (r_ld_dat == DAT_LAST) &&
                          (NW'(r_ld_chunk) == r_ld_num - NW'(1));
  // A chunk counts as loaded once its final beat is actually on the write port.
  assign w_chunk_done   = r_wr_valid && (r_wr_dat == DAT_LAST);

  always_comb begin
    w_ld_state_nxt = r_ld_state;
    case (r_ld_state)
      LD_IDLE: if (w_ld_start_ok) w_ld_state_nxt = LD_LOAD;
      LD_LOAD: if (w_accept && w_ld_last_beat) w_ld_state_nxt = LD_IDLE;
      default: w_ld_state_nxt = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ld_state     <= LD_IDLE;
      r_ld_dat       <= '0;
      r_ld_chunk     <= '0;
      r_ld_num       <= '0;
      r_loaded_cnt   <= '0;
      r_ld_done      <= 1'b0;
      r_wr_valid     <= 1'b0;
      r_wr_sparsemap <= '0;
      r_wr_data      <= '0;
      r_wr_dat       <= '0;
      r_wr_chunk     <= '0;
    end else begin
      r_ld_state <= w_ld_state_nxt;
      r_wr_valid <= w_accept;
      r_ld_done  <= 1'b0;
      if (w_ld_enter) begin
        // A new pass discards progress of any previous one, re-gating reads.
        r_ld_dat     <= '0;
        r_ld_chunk   <= '0;
        r_loaded_cnt <= '0;
        r_ld_num     <= ld_chunk_num_i;
      end else begin
        if (w_accept) begin
          if (r_ld_dat == DAT_LAST) begin
            r_ld_dat   <= '0;
            r_ld_chunk <= r_ld_chunk + CW'(1);
          end else begin
            r_ld_dat <= r_ld_dat + DW'(1);
          end
        end
        if (w_chunk_done) begin
          r_loaded_cnt <= r_loaded_cnt + NW'(1);
          r_ld_done    <= (r_loaded_cnt + NW'(1) == r_ld_num);
        end
      end
      if (w_accept) begin
        r_wr_sparsemap <= in_sparsemap_i;
        r_wr_data      <= in_nonzero_data_i;
        r_wr_dat       <= r_ld_dat;
        r_wr_chunk     <= r_ld_chunk;
      end
    end
  end

  assign wr_valid_o        = r_wr_valid;
  assign wr_sparsemap_o    = r_wr_sparsemap;
  assign wr_nonzero_data_o = r_wr_data;
  assign wr_dat_count_o    = r_wr_dat;
  assign wr_chunk_count_o  = r_wr_chunk;
  assign ld_done_o         = r_ld_done;

  // ---------------- read side ----------------
  // One extra bit so base+num cannot wrap before the range check.
  assign w_rd_end_sum  = (NW+1)'(rd_chunk_base_i) + (NW+1)'(rd_chunk_num_i);
  assign w_rd_start_ok = (rd_chunk_num_i != '0) && (w_rd_end_sum <= CHUNK_LIM);
  // With no load running every chunk is readable; otherwise only finished ones.
  assign w_rd_valid    = (r_rd_state == RD_RUN) &&
                         ((r_ld_state == LD_IDLE) || (NW'(r_rd_chunk) < r_loaded_cnt));
  assign w_rd_final    = (r_rd_chunk == r_rd_last_chunk) && (r_rd_dat == DAT_LAST);
  assign w_rd_consume  = w_rd_valid && !rd_stall_i;

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (rd_start_i && w_rd_start_ok) w_rd_state_nxt = RD_RUN;
      RD_RUN:  if (w_rd_consume && w_rd_final) w_rd_state_nxt = RD_IDLE;
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_state      <= RD_IDLE;
      r_rd_dat        <= '0;
      r_rd_chunk      <= '0;
      r_rd_last_chunk <= '0;
      r_rd_done       <= 1'b0;
      r_rd_err        <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rd_done  <= 1'b0;
      r_rd_err   <= 1'b0;
      if (r_rd_state == RD_IDLE) begin
        if (rd_start_i) begin
          if (w_rd_start_ok) begin
            r_rd_chunk      <= rd_chunk_base_i;
            r_rd_dat        <= '0;
            r_rd_last_chunk <= CW'(w_rd_end_sum - (NW+1)'(1));
          end else begin
            r_rd_err <= 1'b1;
          end
        end
      end else if (w_rd_consume) begin
        if (w_rd_final) begin
          // Address returns to 0 so it reads as idle.
          r_rd_chunk <= '0;
          r_rd_dat   <= '0;
          r_rd_done  <= 1'b1;
        end else if (r_rd_dat == DAT_LAST) begin
          r_rd_dat   <= '0;
          r_rd_chunk <= r_rd_chunk + CW'(1);
        end else begin
          r_rd_dat <= r_rd_dat + DW'(1);
        end
      end
    end
  end

  assign rd_dat_count_o   = r_rd_dat;
  assign rd_chunk_count_o = r_rd_chunk;
  assign rd_valid_o       = w_rd_valid;
  assign rd_last_o        = w_rd_valid && w_rd_final;
  assign rd_done_o        = r_rd_done;
  assign rd_err_o         = r_rd_err;

endmodule
